note_track_engine: RTL and testbench

// - Upstream feeder of the VGA renderer. Holds up to 6 live guitar notes, scrolls them outward from

---
 rtl/note_track_if.sv | 31 +++
 rtl/note_track_engine.sv | 181 ++++++++++++++++++
 tb/tb_note_track_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_track_if.sv
// Bus between the note track engine and its feeder/renderer side.
// The engine uses the slave view; whoever drives spawns, ticks and buttons uses the master view.
interface note_track_if;
  logic        clear;
  logic        tick;
  logic        spawn_valid;
  logic [2:0]  spawn_color;
  logic        spawn_ready;
  logic [5:0]  guitar_in;
  logic [31:0] notes1;
  logic [31:0] notes2;
  logic [31:0] notes3;
  logic [7:0]  p1_score;
  logic [7:0]  p2_score;
  logic        p1_hit;
  logic        p2_hit;
  logic        p1_miss;
  logic        p2_miss;

  modport slave (
    input  clear, tick, spawn_valid, spawn_color, guitar_in,
    output spawn_ready, notes1, notes2, notes3, p1_score, p2_score,
           p1_hit, p2_hit, p1_miss, p2_miss
  );

  modport master (
    output clear, tick, spawn_valid, spawn_color, guitar_in,
    input  spawn_ready, notes1, notes2, notes3, p1_score, p2_score,
           p1_hit, p2_hit, p1_miss, p2_miss
  );
endinterface

// File: rtl/note_track_engine.sv
// Six-slot note track: scrolls notes outward per frame tick, judges both players' strums, keeps scores.
// Optional NOTE_TRACK_STRAY_MISS_EN: a strum with no note in the hit window also counts as a miss.
module note_track_engine #(
  parameter logic [10:0] STEP   = 11'd4,
  parameter logic [10:0] HIT_LO = 11'd252,
  parameter logic [10:0] HIT_HI = 11'd280,
  parameter logic [10:0] X_END  = 11'd300
) (
  input  logic           clock,
  input  logic           reset,
  note_track_if.slave    bus
);

`ifdef NOTE_TRACK_STRAY_MISS_EN
  localparam bit STRAY_MISS = 1'b1;
`else
  localparam bit STRAY_MISS = 1'b0;
`endif

  logic [5:0][15:0] slot_q, slot_d;
  logic [5:0]       empty;
  logic [5:0]       sync1_q, sync2_q, sync3_q, rise;
  logic [7:0]       p1_score_q, p2_score_q;
  logic [8:0]       p1_sum, p2_sum;
  logic [1:0]       p1_cnt, p2_cnt;
  logic             p1_hit_q, p2_hit_q, p1_miss_q, p2_miss_q;
  logic             p1_stray, p2_stray, p1_retire_miss, p2_retire_miss;
  logic             spawned, color_ok;
  logic [3:0]       win;
  logic [11:0]      moved;

  // Guitar lane order is red, green, yellow; slot colour field is {red,yellow,green}.
  function automatic logic [2:0] lane_colour(input int lane);
    case (lane)
      0:       return 3'b100;
      1:       return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  // Returns {found, index}: the in-window undone note of this colour furthest out, lowest index on ties.
  function automatic logic [3:0] pick_winner(input logic [5:0][15:0] slots,
                                             input logic [2:0] colour, input logic player2);
    logic        found;
    logic [2:0]  idx;
    logic [10:0] best;
    logic        done;
    found = 1'b0;
    idx   = 3'd0;
    best  = 11'd0;
    for (int s = 0; s < 6; s++) begin
      done = player2 ? slots[s][0] : slots[s][1];
      if (slots[s][4:2] == colour && !done &&
          slots[s][15:5] >= HIT_LO && slots[s][15:5] <= HIT_HI &&
          (!found || slots[s][15:5] > best)) begin
        found = 1'b1;
        idx   = 3'(s);
        best  = slots[s][15:5];
      end
    end
    return {found, idx};
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_empty
    assign empty[g] = (slot_q[g][4:2] == 3'b000);
  end

  assign rise            = sync2_q & ~sync3_q;
  assign bus.spawn_ready = |empty;
  assign color_ok        = (bus.spawn_color == 3'b001) || (bus.spawn_color == 3'b010) ||
                           (bus.spawn_color == 3'b100);

  // Judging uses pre-tick offsets; hits mark done bits before retirement so a hit note never also misses.
  always_comb begin
    slot_d         = slot_q;
    p1_cnt         = 2'd0;
    p2_cnt         = 2'd0;
    p1_stray       = 1'b0;
    p2_stray       = 1'b0;
    p1_retire_miss = 1'b0;
    p2_retire_miss = 1'b0;
    spawned        = 1'b0;
    win            = 4'd0;
    moved          = 12'd0;

    for (int l = 0; l < 3; l++) begin
      win = pick_winner(slot_q, lane_colour(l), 1'b0);
      if (rise[l]) begin
        if (win[3]) begin
          slot_d[win[2:0]][1] = 1'b1;
          p1_cnt = p1_cnt + 2'd1;
        end else begin
          p1_stray = 1'b1;
        end
      end
      win = pick_winner(slot_q, lane_colour(l), 1'b1);
      if (rise[l+3]) begin
        if (win[3]) begin
          slot_d[win[2:0]][0] = 1'b1;
          p2_cnt = p2_cnt + 2'd1;
        end else begin
          p2_stray = 1'b1;
        end
      end
    end

    if (bus.tick) begin
      for (int s = 0; s < 6; s++) begin
        if (!empty[s]) begin
          moved = {1'b0, slot_q[s][15:5]} + {1'b0, STEP};
          if (moved > {1'b0, X_END}) begin
            if (!slot_d[s][1]) p1_retire_miss = 1'b1;
            if (!slot_d[s][0]) p2_retire_miss = 1'b1;
            slot_d[s] = 16'd0;
          end else begin
            slot_d[s][15:5] = moved[10:0];
          end
        end
      end
    end

    // Malformed colours still complete the handshake but never occupy a slot.
    if (bus.spawn_valid && bus.spawn_ready && color_ok) begin
      for (int s = 0; s < 6; s++) begin
        if (!spawned && empty[s]) begin
          slot_d[s] = {11'd0, bus.spawn_color, 2'b00};
          spawned   = 1'b1;
        end
      end
    end
  end

  assign p1_sum = {1'b0, p1_score_q} + {7'd0, p1_cnt};
  assign p2_sum = {1'b0, p2_score_q} + {7'd0, p2_cnt};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      p1_hit_q   <= 1'b0;
      p2_hit_q   <= 1'b0;
      p1_miss_q  <= 1'b0;
      p2_miss_q  <= 1'b0;
    end else begin
      sync1_q <= bus.guitar_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (bus.clear) begin
        slot_q     <= '0;
        p1_score_q <= '0;
        p2_score_q <= '0;
        p1_hit_q   <= 1'b0;
        p2_hit_q   <= 1'b0;
        p1_miss_q  <= 1'b0;
        p2_miss_q  <= 1'b0;
      end else begin
        slot_q     <= slot_d;
        p1_score_q <= p1_sum[8] ? 8'hFF : p1_sum[7:0];
        p2_score_q <= p2_sum[8] ? 8'hFF : p2_sum[7:0];
        p1_hit_q   <= (p1_cnt != 2'd0);
        p2_hit_q   <= (p2_cnt != 2'd0);
        p1_miss_q  <= p1_retire_miss | (STRAY_MISS & p1_stray);
        p2_miss_q  <= p2_retire_miss | (STRAY_MISS & p2_stray);
      end
    end
  end

  assign bus.notes1   = {slot_q[0], slot_q[1]};
  assign bus.notes2   = {slot_q[2], slot_q[3]};
  assign bus.notes3   = {slot_q[4], slot_q[5]};
  assign bus.p1_score = p1_score_q;
  assign bus.p2_score = p2_score_q;
  assign bus.p1_hit   = p1_hit_q;
  assign bus.p2_hit   = p2_hit_q;
  assign bus.p1_miss  = p1_miss_q;
  assign bus.p2_miss  = p2_miss_q;
endmodule

// File: tb/tb_note_track_engine.sv
// Self-checking bench for note_track_engine; a second instance with a widened hit window
// exercises the hit-and-retire-in-one-cycle corner.
module tb_note_track_engine;
`ifdef NOTE_TRACK_STRAY_MISS_EN
  localparam bit STRAY = 1'b1;
`else
  localparam bit STRAY = 1'b0;
`endif
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  typedef struct packed {
    logic       p1_hit;
    logic       p2_hit;
    logic       p1_miss;
    logic       p2_miss;
    logic [7:0] p1_score;
    logic [7:0] p2_score;
  } exp_t;

  typedef struct packed {
    logic [5:0] guitar;
    exp_t       want;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear, tick, spawn_valid;
  logic [2:0] spawn_color;
  logic [5:0] guitar_in;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  vec_t       vecs[5];

  note_track_if bus();
  note_track_if bus_w();

  assign bus.clear         = clear;
  assign bus.tick          = tick;
  assign bus.spawn_valid   = spawn_valid;
  assign bus.spawn_color   = spawn_color;
  assign bus.guitar_in     = guitar_in;
  assign bus_w.clear       = clear;
  assign bus_w.tick        = tick;
  assign bus_w.spawn_valid = spawn_valid;
  assign bus_w.spawn_color = spawn_color;
  assign bus_w.guitar_in   = guitar_in;

  note_track_engine dut (.clock(clock), .reset(reset), .bus(bus));
  note_track_engine #(.HIT_HI(11'd300)) dut_w (.clock(clock), .reset(reset), .bus(bus_w));

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic spawn(input logic [2:0] c);
    spawn_valid = 1'b1;
    spawn_color = c;
    cyc(1);
    spawn_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic press_raw(input logic [5:0] g);
    guitar_in = g;
    cyc(1);
    guitar_in = '0;
    cyc(3);
  endtask

  // Strum, then pop the scoreboard entry on the judging edge three cycles after the pin change.
  task automatic applyStimulus(input logic [5:0] g, input exp_t e);
    exp_t want;
    sb.push_back(e);
    guitar_in = g;
    cyc(1);
    guitar_in = '0;
    cyc(1);
    checkOutput("strum_early", {28'd0, bus.p1_hit, bus.p2_hit, bus.p1_miss, bus.p2_miss}, 32'd0);
    cyc(1);
    want = sb.pop_front();
    checkOutput("strum_pulses", {28'd0, bus.p1_hit, bus.p2_hit, bus.p1_miss, bus.p2_miss},
                {28'd0, want.p1_hit, want.p2_hit, want.p1_miss, want.p2_miss});
    checkOutput("strum_scores", {16'd0, bus.p1_score, bus.p2_score},
                {16'd0, want.p1_score, want.p2_score});
    cyc(1);
    checkOutput("strum_pulse_width", {28'd0, bus.p1_hit, bus.p2_hit, bus.p1_miss, bus.p2_miss}, 32'd0);
  endtask

  task automatic check_idle(input string name);
    checkOutput({name, "_notes1"}, bus.notes1, 32'd0);
    checkOutput({name, "_notes2"}, bus.notes2, 32'd0);
    checkOutput({name, "_notes3"}, bus.notes3, 32'd0);
    checkOutput({name, "_scores"}, {16'd0, bus.p1_score, bus.p2_score}, 32'd0);
    checkOutput({name, "_pulses"}, {28'd0, bus.p1_hit, bus.p2_hit, bus.p1_miss, bus.p2_miss}, 32'd0);
    checkOutput({name, "_ready"}, {31'd0, bus.spawn_ready}, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] want_word;
    vecs[0] = '{6'b000001, '{1'b1, 1'b0, 1'b0,  1'b0, 8'd1, 8'd0}};
    vecs[1] = '{6'b000001, '{1'b1, 1'b0, 1'b0,  1'b0, 8'd2, 8'd0}};
    vecs[2] = '{6'b000001, '{1'b0, 1'b0, STRAY, 1'b0, 8'd2, 8'd0}};
    vecs[3] = '{6'b111110, '{1'b1, 1'b1, 1'b0,  1'b0, 8'd4, 8'd3}};
    vecs[4] = '{6'b001000, '{1'b0, 1'b1, 1'b0,  1'b0, 8'd4, 8'd4}};

    reset = 1'b1; clear = 1'b0; tick = 1'b0; spawn_valid = 1'b0;
    spawn_color = 3'b000; guitar_in = '0;
    cyc(2);
    check_idle("reset");
    reset = 1'b0;
    cyc(1);

    // Single red note scrolled to 260 and hit by P1.
    spawn(RED);
    checkOutput("spawn_slot0", bus.notes1, 32'h0010_0000);
    ticks(65);
    checkOutput("scroll_260", bus.notes1, 32'h2090_0000);
    applyStimulus(6'b000001, '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0});
    want_word = {11'd260, 3'b100, 2'b10, 16'h0};
    checkOutput("hit_done_bit", bus.notes1, want_word);

    // Clear wins over a simultaneous spawn and tick.
    clear = 1'b1; spawn_valid = 1'b1; spawn_color = RED; tick = 1'b1;
    cyc(1);
    clear = 1'b0; spawn_valid = 1'b0; tick = 1'b0;
    check_idle("clear");

    // Fill all six slots, stall the seventh until slot 0 retires.
    spawn(RED);
    ticks(1);
    spawn(YEL); spawn(GRN); spawn(RED); spawn(YEL); spawn(GRN);
    checkOutput("fill_notes1", bus.notes1, 32'h0090_0008);
    checkOutput("fill_notes2", bus.notes2, 32'h0004_0010);
    checkOutput("fill_notes3", bus.notes3, 32'h0008_0004);
    checkOutput("fill_ready", {31'd0, bus.spawn_ready}, 32'd0);
    spawn_valid = 1'b1; spawn_color = GRN;
    cyc(1);
    checkOutput("stall_notes1", bus.notes1, 32'h0090_0008);
    checkOutput("stall_notes3", bus.notes3, 32'h0008_0004);
    ticks(74);
    checkOutput("pre_retire", bus.notes1, 32'h2590_0008 | 32'h0000_2500);
    ticks(1);
    checkOutput("retire_notes1", bus.notes1, 32'h0000_2588);
    checkOutput("retire_miss", {30'd0, bus.p1_miss, bus.p2_miss}, 32'd3);
    checkOutput("retire_ready", {31'd0, bus.spawn_ready}, 32'd1);
    cyc(1);
    spawn_valid = 1'b0;
    checkOutput("reuse_slot0", bus.notes1, 32'h0004_2588);
    checkOutput("reuse_ready", {31'd0, bus.spawn_ready}, 32'd0);
    do_clear();

    // Malformed colour is swallowed; green note retires past X_END with a double miss.
    spawn(3'b011);
    checkOutput("bad_colour_notes", bus.notes1, 32'd0);
    checkOutput("bad_colour_ready", {31'd0, bus.spawn_ready}, 32'd1);
    spawn(GRN);
    ticks(75);
    checkOutput("at_x_end", bus.notes1, 32'h2584_0000);
    checkOutput("at_x_end_miss", {30'd0, bus.p1_miss, bus.p2_miss}, 32'd0);
    ticks(1);
    checkOutput("past_x_end", bus.notes1, 32'd0);
    checkOutput("past_x_end_miss", {30'd0, bus.p1_miss, bus.p2_miss}, 32'd3);
    cyc(1);
    checkOutput("miss_width", {30'd0, bus.p1_miss, bus.p2_miss}, 32'd0);

    // Strum with the only note far outside the window.
    spawn(GRN);
    ticks(25);
    applyStimulus(6'b010000, '{1'b0, 1'b0, 1'b0, STRAY, 8'd0, 8'd0});
    do_clear();

    // Table of strums over red@260, red@252, green@252, yellow@252.
    spawn(RED);
    ticks(2);
    spawn(RED); spawn(GRN); spawn(YEL);
    ticks(63);
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i].guitar, vecs[i].want);
    checkOutput("table_notes1", bus.notes1, 32'h2093_1F93);
    checkOutput("table_notes2", bus.notes2, 32'h1F87_1F8B);
    do_clear();

    // Two red notes tied at HIT_HI: lowest index wins; one tick later nothing is hittable.
    spawn(RED); spawn(RED);
    ticks(70);
    applyStimulus(6'b001000, '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
    checkOutput("tie_notes1", bus.notes1, 32'h2311_2310);
    ticks(1);
    checkOutput("above_hi_notes1", bus.notes1, 32'h2391_2390);
    applyStimulus(6'b000001, '{1'b0, 1'b0, STRAY, 1'b0, 8'd0, 8'd1});
    do_clear();

    // Judge, tick and spawn on one edge with the note at 300 (in window only for the wide instance).
    spawn(RED);
    ticks(75);
    guitar_in = 6'b000001;
    cyc(1);
    guitar_in = '0;
    cyc(1);
    tick = 1'b1; spawn_valid = 1'b1; spawn_color = YEL;
    cyc(1);
    tick = 1'b0; spawn_valid = 1'b0;
    checkOutput("same_cycle_w_pulses", {28'd0, bus_w.p1_hit, bus_w.p2_hit, bus_w.p1_miss, bus_w.p2_miss},
                32'b1001);
    checkOutput("same_cycle_w_notes1", bus_w.notes1, 32'h0000_0008);
    checkOutput("same_cycle_w_score", {24'd0, bus_w.p1_score}, 32'd1);
    checkOutput("same_cycle_pulses", {28'd0, bus.p1_hit, bus.p2_hit, bus.p1_miss, bus.p2_miss}, 32'b0011);
    checkOutput("same_cycle_score", {24'd0, bus.p1_score}, 32'd0);
    do_clear();

    // Six hits per player per round; the last round pushes both scores through saturation.
    for (int r = 0; r < 43; r++) begin
      spawn(RED); spawn(GRN); spawn(YEL); spawn(RED); spawn(GRN); spawn(YEL);
      ticks(63);
      if (r < 42) begin
        press_raw(6'b111111);
        press_raw(6'b111111);
      end else begin
        checkOutput("score_pre_sat", {16'd0, bus.p1_score, bus.p2_score}, {16'd0, 8'd252, 8'd252});
        applyStimulus(6'b111111, '{1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255});
        applyStimulus(6'b111111, '{1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255});
      end
      ticks(13);
    end
    checkOutput("done_retire_miss", {30'd0, bus.p1_miss, bus.p2_miss}, 32'd0);
    checkOutput("done_retire_notes", bus.notes1 | bus.notes2 | bus.notes3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
